// File: rtl/dummy_cp_pkg.sv
// Shared types for the streaming copy kernel: default pixel width,
// pixel type and the iteration FSM state encoding.
package dummy_cp_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef logic [DEFAULT_WIDTH-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/dummy_cp_delay_pipe.sv
// LATENCY-stage valid+data shift register. rst clears valids and data,
// clr clears only the valids (data stages keep whatever they held).
// drain_empty reports that every stage will be empty after the next edge.
module dummy_cp_delay_pipe
    import dummy_cp_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             drain_empty
);

    logic [LATENCY-1:0] vld;
    logic [WIDTH-1:0]   dat [LATENCY];

    // Shift valids every edge; a data stage only moves when its upstream stage
    // is valid, so the output data holds its last value between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat[i] <= '0;
            end
        end else if (clr) begin
            vld <= '0;
        end else begin
            vld[0] <= in_valid;
            if (in_valid) begin
                dat[0] <= in_data;
            end
            for (int i = 1; i < LATENCY; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    dat[i] <= dat[i-1];
                end
            end
        end
    end

    // Nothing is entering and no stage except the last one holds a pixel,
    // so after this edge the whole pipe is empty.
    always_comb begin
        drain_empty = !in_valid;
        for (int i = 0; i < LATENCY - 1; i++) begin
            if (vld[i]) begin
                drain_empty = 1'b0;
            end
        end
    end

    assign out_valid = vld[LATENCY-1];
    assign out_data  = dat[LATENCY-1];

endmodule

// File: rtl/dummy_cp_app_in_cgra_1_core.sv
// Streaming copy kernel: walks an IMG_W x IMG_H domain, reading one pixel per
// cycle and emitting it unchanged LATENCY edges later. Statically scheduled,
// no back-pressure. rst_n is a synchronous ACTIVE-HIGH reset despite its name.
// Optional macro DUMMY_CP_DONE_EN adds a 'done' output that is high in DONE.
module dummy_cp_app_in_cgra_1_core
    import dummy_cp_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int IMG_W       = 64,
    parameter int IMG_H       = 64,
    parameter int LATENCY     = 1,
    parameter int START_DELAY = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
`ifdef DUMMY_CP_DONE_EN
    output logic             done,
`endif
    output logic             dummy_cp_app_in_cgra_1_dummy_cp_app_in_cgra_1_update_0_write_valid,
    output logic [WIDTH-1:0] dummy_cp_app_in_cgra_1_dummy_cp_app_in_cgra_1_update_0_write [0:0],
    output logic             raw_oc_raw_update_0_read_en,
    input  logic [WIDTH-1:0] raw_oc_raw_update_0_read [0:0]
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int DW = (START_DELAY > 0) ? $clog2(START_DELAY + 1) : 1;

    localparam logic [XW-1:0] X_LAST   = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(IMG_H - 1);
    localparam logic [DW-1:0] DLY_LAST = DW'(START_DELAY);

    state_t        state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [DW-1:0] dly;
    logic          restart;
    logic          read_en;
    logic          pipe_empty;

    // Reset and flush both restart the iteration; reading is suppressed in
    // that cycle so a discarded capture never enters the pipe.
    assign restart = rst_n | flush;
    assign read_en = (state == RUN) && !restart;

    assign raw_oc_raw_update_0_read_en = read_en;

`ifdef DUMMY_CP_DONE_EN
    assign done = (state == DONE) && !restart;
`endif

    // Iteration FSM with the start-delay counter and the x/y domain walk.
    always_ff @(posedge clk) begin
        if (restart) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
            dly   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dly == DLY_LAST) begin
                        state <= RUN;
                    end else begin
                        dly <= dly + DW'(1);
                    end
                end
                RUN: begin
                    if (x == X_LAST) begin
                        x <= '0;
                        if (y == Y_LAST) begin
                            y     <= '0;
                            state <= DRAIN;
                        end else begin
                            y <= y + YW'(1);
                        end
                    end else begin
                        x <= x + XW'(1);
                    end
                end
                DRAIN: begin
                    if (pipe_empty) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    dummy_cp_delay_pipe #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk         (clk),
        .rst         (rst_n),
        .clr         (flush),
        .in_valid    (read_en),
        .in_data     (raw_oc_raw_update_0_read[0]),
        .out_valid   (dummy_cp_app_in_cgra_1_dummy_cp_app_in_cgra_1_update_0_write_valid),
        .out_data    (dummy_cp_app_in_cgra_1_dummy_cp_app_in_cgra_1_update_0_write[0]),
        .drain_empty (pipe_empty)
    );

endmodule

// File: tb/tb_dummy_cp_app_in_cgra_1_core.sv
// Bench for the copy kernel: instance a (LATENCY=1, START_DELAY=0) and
// instance b (LATENCY=3, START_DELAY=5) share clock, reset and flush.
module tb_dummy_cp_app_in_cgra_1_core;

    localparam int LAT_B = 3;
    localparam int DLY_B = 5;
    localparam int FRAME = 64 * 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic [15:0] rd_a [0:0];
    logic [15:0] rd_b [0:0];
    logic [15:0] wa   [0:0];
    logic [15:0] wb   [0:0];
    logic        re_a, re_b, wv_a, wv_b;
`ifdef DUMMY_CP_DONE_EN
    logic        done_a, done_b;
`endif

    logic [15:0] exp_a [$];
    logic [15:0] exp_b [$];
    int          when_b [$];

    int tests = 0;
    int fails = 0;
    int edge_n = 0;
    int rel = 0;
    int first_a = 0;
    int first_b = 0;
    int na_rd = 0, na_wr = 0, nb_rd = 0, nb_wr = 0;
    int last_wv_a = 0;
    int first_done = 0;

    always #5 clk = ~clk;

    dummy_cp_app_in_cgra_1_core #(
        .WIDTH(16), .IMG_W(64), .IMG_H(64), .LATENCY(1), .START_DELAY(0)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
`ifdef DUMMY_CP_DONE_EN
        .done  (done_a),
`endif
        .dummy_cp_app_in_cgra_1_dummy_cp_app_in_cgra_1_update_0_write_valid (wv_a),
        .dummy_cp_app_in_cgra_1_dummy_cp_app_in_cgra_1_update_0_write       (wa),
        .raw_oc_raw_update_0_read_en (re_a),
        .raw_oc_raw_update_0_read    (rd_a)
    );

    dummy_cp_app_in_cgra_1_core #(
        .WIDTH(16), .IMG_W(64), .IMG_H(64), .LATENCY(LAT_B), .START_DELAY(DLY_B)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
`ifdef DUMMY_CP_DONE_EN
        .done  (done_b),
`endif
        .dummy_cp_app_in_cgra_1_dummy_cp_app_in_cgra_1_update_0_write_valid (wv_b),
        .dummy_cp_app_in_cgra_1_dummy_cp_app_in_cgra_1_update_0_write       (wb),
        .raw_oc_raw_update_0_read_en (re_b),
        .raw_oc_raw_update_0_read    (rd_b)
    );

    function automatic logic [15:0] rnd16();
        return 16'($urandom_range(0, 65535));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive data, record reads as expected outputs, advance one
    // edge, then score any write against the expected queue.
    task automatic tick(input logic [15:0] da, input logic [15:0] db);
        logic [15:0] e;
        int          t;
        rd_a[0] = da;
        rd_b[0] = db;
        #1;
        if (re_a === 1'b1) begin
            exp_a.push_back(da);
            na_rd++;
        end
        if (re_b === 1'b1) begin
            exp_b.push_back(db);
            when_b.push_back(edge_n + 1);
            nb_rd++;
        end
        @(posedge clk);
        edge_n++;
        #1;
        if (rst_n || flush) begin
            exp_a.delete();
            exp_b.delete();
            when_b.delete();
        end else begin
            rel++;
            if (re_a === 1'b1 && first_a == 0) first_a = rel;
            if (re_b === 1'b1 && first_b == 0) first_b = rel;
        end
`ifdef DUMMY_CP_DONE_EN
        if (done_a === 1'b1 && first_done == 0) first_done = edge_n;
`endif
        if (wv_a === 1'b1) begin
            na_wr++;
            last_wv_a = edge_n;
            check("a_write_expected", 32'(exp_a.size() != 0), 32'd1);
            if (exp_a.size() != 0) begin
                e = exp_a.pop_front();
                check("a_write_data", 32'(wa[0]), 32'(e));
            end
        end
        if (wv_b === 1'b1) begin
            nb_wr++;
            check("b_write_expected", 32'(exp_b.size() != 0), 32'd1);
            if (exp_b.size() != 0) begin
                e = exp_b.pop_front();
                t = when_b.pop_front();
                check("b_write_data", 32'(wb[0]), 32'(e));
                check("b_write_latency", 32'(edge_n), 32'(t + LAT_B - 1));
            end
        end
    endtask

    initial begin
        rd_a[0] = '0;
        rd_b[0] = '0;

        // Reset held for two edges: all strobes and data low.
        rst_n = 1'b1;
        flush = 1'b0;
        repeat (2) begin
            tick(16'h0000, 16'h0000);
            check("rst_read_en", 32'(re_a), 32'd0);
            check("rst_write_valid", 32'(wv_a), 32'd0);
            check("rst_write", 32'(wa[0]), 32'd0);
            check("rst_b_read_en", 32'(re_b), 32'd0);
            check("rst_b_write", 32'(wb[0]), 32'd0);
`ifdef DUMMY_CP_DONE_EN
            check("rst_done", 32'(done_a), 32'd0);
`endif
        end

        // Release: instance a reads right away.
        rst_n = 1'b0;
        rel = 0;
        first_a = 0;
        first_b = 0;
        tick(16'h0000, rnd16());
        check("first_read_en", 32'(re_a), 32'd1);

        // Directed latency pair.
        tick(16'hA5A5, rnd16());
        check("lat_valid_0", 32'(wv_a), 32'd1);
        check("lat_data_0", 32'(wa[0]), 32'h0000A5A5);
        tick(16'h1234, rnd16());
        check("lat_valid_1", 32'(wv_a), 32'd1);
        check("lat_data_1", 32'(wa[0]), 32'h00001234);

        // Remainder of the first frame with random data, plus idle margin.
        repeat (4200) tick(rnd16(), rnd16());
        check("a_start_cycle", 32'(first_a), 32'd1);
        check("b_start_cycle", 32'(first_b), 32'(1 + DLY_B));
        check("a_reads", 32'(na_rd), 32'(FRAME));
        check("a_writes", 32'(na_wr), 32'(FRAME));
        check("b_reads", 32'(nb_rd), 32'(FRAME));
        check("b_writes", 32'(nb_wr), 32'(FRAME));
        check("a_queue_left", 32'(exp_a.size()), 32'd0);
        check("b_queue_left", 32'(exp_b.size()), 32'd0);
        check("end_read_en", 32'(re_a), 32'd0);
        check("end_write_valid", 32'(wv_a), 32'd0);
        check("end_b_read_en", 32'(re_b), 32'd0);
        check("end_b_write_valid", 32'(wv_b), 32'd0);
`ifdef DUMMY_CP_DONE_EN
        check("done_high", 32'(done_a), 32'd1);
        check("done_rise", 32'(first_done), 32'(last_wv_a + 1));
`endif

        // Flush held for three edges: no reads while it is high.
        flush = 1'b1;
        repeat (3) begin
            tick(rnd16(), rnd16());
            check("flush_hold_read_en", 32'(re_a), 32'd0);
        end
`ifdef DUMMY_CP_DONE_EN
        check("flush_done", 32'(done_a), 32'd0);
`endif
        flush = 1'b0;
        na_rd = 0; na_wr = 0; nb_rd = 0; nb_wr = 0;

        // Run to 100 reads, then flush for one cycle mid-frame.
        for (int i = 0; i < 200 && na_rd < 100; i++) tick(rnd16(), rnd16());
        check("pre_flush_reads", 32'(na_rd), 32'd100);
        flush = 1'b1;
        tick(16'hDEAD, 16'hBEEF);
        check("flush_read_en", 32'(re_a), 32'd0);
        check("flush_write_valid", 32'(wv_a), 32'd0);
        check("flush_b_write_valid", 32'(wv_b), 32'd0);
        flush = 1'b0;
        na_rd = 0; na_wr = 0; nb_rd = 0; nb_wr = 0;

        // A fresh full frame must follow, with nothing stale leaking out.
        repeat (4300) tick(rnd16(), rnd16());
        check("refill_a_reads", 32'(na_rd), 32'(FRAME));
        check("refill_a_writes", 32'(na_wr), 32'(FRAME));
        check("refill_b_reads", 32'(nb_rd), 32'(FRAME));
        check("refill_b_writes", 32'(nb_wr), 32'(FRAME));
        check("refill_a_queue", 32'(exp_a.size()), 32'd0);
        check("refill_b_queue", 32'(exp_b.size()), 32'd0);
`ifdef DUMMY_CP_DONE_EN
        check("refill_done", 32'(done_a), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
